// File: rtl/tc_bus_arbiter_pkg.sv
// Shared encodings for the TC bus arbiter: FSM states, grant codes and the
// TC register map used by anything talking to the timer/counter port.
package tc_bus_arbiter_pkg;

    // TC device word-address width (addresses carried as [DEV_ADDR_WD:1])
    localparam int DEV_ADDR_WD = 2;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_WAIT  = 2'b10
    } arb_state_e;

    // Grant / last-grant encodings
    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_gnt_e;

    // TC register word offsets
    localparam logic [DEV_ADDR_WD-1:0] TC_CTRL   = 2'd0;
    localparam logic [DEV_ADDR_WD-1:0] TC_PRESET = 2'd1;
    localparam logic [DEV_ADDR_WD-1:0] TC_COUNT  = 2'd2;
    localparam logic [DEV_ADDR_WD-1:0] TC_STATUS = 2'd3;

endpackage

// File: rtl/tc_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick. On a tie the master that did not win last time
// is chosen; a lone requester always wins. Purely combinational.
module tc_bus_arbiter_rr_arb2
    import tc_bus_arbiter_pkg::*;
(
    input  logic     req0_i,
    input  logic     req1_i,
    input  arb_gnt_e last_i,
    output arb_gnt_e gnt_o,
    output logic     valid_o
);

    // Select winner from the eligible set and the previous grant
    always_comb begin
        valid_o = req0_i | req1_i;
        gnt_o   = ARB_M0;
        if (req0_i && req1_i) begin
            gnt_o = (last_i == ARB_M0) ? ARB_M1 : ARB_M0;
        end else if (req1_i) begin
            gnt_o = ARB_M1;
        end else begin
            gnt_o = ARB_M0;
        end
    end

endmodule

// File: rtl/tc_bus_arbiter.sv
// Shares the timer/counter port between two bus masters. Each granted access
// runs IDLE -> ISSUE (write strobe) -> WAIT (TC read register settles) and the
// captured read data is returned with a one-cycle ack. Also latches rising
// edges of the TC interrupt into a sticky pending bit.
module tc_bus_arbiter
    import tc_bus_arbiter_pkg::*;
#(
    parameter int AW = 2,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW:1]   m0_add_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW:1]   m1_add_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic [AW:1]   tc_add_o,
    output logic          tc_we_o,
    output logic [DW-1:0] tc_dat_o,
    input  logic [DW-1:0] tc_dat_i,
    input  logic          tc_irq_i,
    input  logic          irq_ack_i,
    output logic          irq_o,
    output logic          busy_o
);

    arb_state_e    state_q, state_d;
    arb_gnt_e      last_q;
    arb_gnt_e      gnt_q;
    arb_gnt_e      arb_gnt_s;
    logic          arb_valid_s;
    logic          grant_s;
    logic          done_s;
    logic          m0_elig_s, m1_elig_s;
    logic [AW:1]   win_add_s;
    logic          win_we_s;
    logic [DW-1:0] win_dat_s;
    logic [AW:1]   tc_add_q;
    logic          tc_we_q;
    logic [DW-1:0] tc_dat_q;
    logic [DW-1:0] m0_dat_q, m1_dat_q;
    logic          m0_ack_q, m1_ack_q;
    logic          busy_q;
    logic          irq_dly_q;
    logic          irq_q;
    logic          irq_rise_s;

    // A master in its own ack cycle has already been served; ignore its req
    assign m0_elig_s = m0_req_i & ~m0_ack_q;
    assign m1_elig_s = m1_req_i & ~m1_ack_q;

    tc_bus_arbiter_rr_arb2 u_rr_arb2 (
        .req0_i  (m0_elig_s),
        .req1_i  (m1_elig_s),
        .last_i  (last_q),
        .gnt_o   (arb_gnt_s),
        .valid_o (arb_valid_s)
    );

    // Steer the winning master's request fields toward the TC registers
    always_comb begin
        if (arb_gnt_s == ARB_M1) begin
            win_add_s = m1_add_i;
            win_we_s  = m1_we_i;
            win_dat_s = m1_dat_i;
        end else begin
            win_add_s = m0_add_i;
            win_we_s  = m0_we_i;
            win_dat_s = m0_dat_i;
        end
    end

    // Next-state logic: ISSUE and WAIT each last exactly one cycle
    always_comb begin
        state_d = state_q;
        grant_s = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (arb_valid_s) begin
                    state_d = ARB_ISSUE;
                    grant_s = 1'b1;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: state_d = ARB_WAIT;
            ARB_WAIT: begin
                state_d = ARB_IDLE;
                done_s  = 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping, TC request registers, read-data capture and acks
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q   <= ARB_M1;
            gnt_q    <= ARB_M0;
            tc_add_q <= '0;
            tc_we_q  <= 1'b0;
            tc_dat_q <= '0;
            m0_dat_q <= '0;
            m1_dat_q <= '0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            m0_ack_q <= done_s && (gnt_q == ARB_M0);
            m1_ack_q <= done_s && (gnt_q == ARB_M1);
            if (grant_s) begin
                gnt_q    <= arb_gnt_s;
                last_q   <= arb_gnt_s;
                tc_add_q <= win_add_s;
                tc_we_q  <= win_we_s;
                tc_dat_q <= win_dat_s;
                busy_q   <= 1'b1;
            end else if (state_q == ARB_ISSUE) begin
                // strobe is only valid for the ISSUE cycle
                tc_we_q <= 1'b0;
            end else if (done_s) begin
                busy_q <= 1'b0;
                if (gnt_q == ARB_M1) begin
                    m1_dat_q <= tc_dat_i;
                end else begin
                    m0_dat_q <= tc_dat_i;
                end
            end
        end
    end

    // New interrupt only on a 0->1 edge of the TC level
    assign irq_rise_s = tc_irq_i & ~irq_dly_q;

    // Sticky pending interrupt; a new edge beats a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            irq_dly_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            irq_dly_q <= tc_irq_i;
            if (irq_rise_s) begin
                irq_q <= 1'b1;
            end else if (irq_ack_i) begin
                irq_q <= 1'b0;
            end else begin
                irq_q <= irq_q;
            end
        end
    end

    assign tc_add_o = tc_add_q;
    assign tc_we_o  = tc_we_q;
    assign tc_dat_o = tc_dat_q;
    assign m0_dat_o = m0_dat_q;
    assign m1_dat_o = m1_dat_q;
    assign m0_ack_o = m0_ack_q;
    assign m1_ack_o = m1_ack_q;
    assign busy_o   = busy_q;
    assign irq_o    = irq_q;

endmodule
